alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Round-robin scheduler sharing one alu (8-bit ADD/SUB/AND/OR/NOT, zero flag) between two requesters.
//  Per-requester valid/ready request channels; one shared response channel tagged with requester id.
//  Operands are registered before the ALU and the result after it; instantiates alu, never modifies it.
// PARAMETERS
//  W        8   operand/result width; must match alu (8)
//  CNT_W    16  width of completed-operation counter
// PORTS
//  clk         in   1     single clock, all state on rising edge
//  rst         in   1     synchronous, active-high reset
//  req0_valid  in   1     requester 0 has an operation
//  req0_ready  out  1     requester 0 op accepted this cycle (valid&ready)
//  req0_a      in   W     requester 0 operand a
//  req0_b      in   W     requester 0 operand b
//  req0_op     in   3     requester 0 opcode (000 ADD,001 SUB,010 AND,011 OR,100 NOT)
//  req1_valid/req1_ready/req1_a/req1_b/req1_op   same as above, requester 1
//  resp_valid  out  1     response available
//  resp_ready  in   1     consumer takes response (valid&ready)
//  resp_id     out  1     requester that issued the op
//  resp_result out  W     ALU result
//  resp_zero   out  1     ALU zero flag
//  resp_err    out  1     opcode was 101..111 (result 0, zero 1 as alu defines)
//  busy        out  1     state != IDLE
//  ops_done    out  CNT_W count of response handshakes, saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (req0 preferred), resp_valid=0, resp_id=0, resp_result=0,
//   resp_zero=0, resp_err=0, ops_done=0, busy=0, both req*_ready=0.
//  FSM: IDLE -> EXEC -> RESP -> (IDLE | EXEC).
//   IDLE: if any req valid, grant one, assert its ready combinationally, latch a,b,op,id; -> EXEC.
//   EXEC: alu driven from latched regs; result/zero/err/id registered into resp_*; -> RESP.
//   RESP: resp_valid=1; all resp_* stable until resp_ready. On resp_ready: ops_done++;
//    if a req is valid, accept it in the same cycle (grant as IDLE) -> EXEC, else -> IDLE.
//  Grant: at most one req*_ready high per cycle; only in IDLE or RESP&&resp_ready.
//   Both valid: grant requester != rr_ptr-preferred loser, i.e. preferred = rr_ptr;
//   after each grant rr_ptr <= ~granted_id. Single valid: grant it regardless of rr_ptr.
//  Latency: accept at cycle T -> resp_valid at T+2. Peak throughput 1 op / 2 cycles.
//  req*_ready is a function of state, rr_ptr, valids, resp_ready only (never of operands).
//  A requester may drop valid without handshake; no op is latched unless valid&ready.
//  Arithmetic: ADD/SUB wrap mod 2^W, no carry/borrow out; NOT uses a only.
//  resp_err=1 iff latched op > 3'b100; op still issued and completed normally.
//  ops_done saturates at 2^CNT_W-1, no wrap.
//  Reset mid-operation (EXEC or RESP): in-flight op discarded, no response emitted.
//  resp_ready while resp_valid=0: ignored.
// STRUCTURE
//  Shared package alu_pkg: W, opcode localparams (OP_ADD..OP_NOT), state enum
//   (ST_IDLE, ST_EXEC, ST_RESP) and is_valid_op() function; used by alu tests too.
//  One sub-module: rr_arb2 (2-way round-robin grant: valid[1:0], ptr, en -> gnt[1:0]).
//  alu instantiated as-is inside EXEC path; FSM, operand regs, response regs, counter local.
// TESTING
//  1 Single op: req0 a=8'h0F b=8'h01 op=000 -> req0_ready same cycle, resp_valid T+2,
//    result=8'h10, zero=0, id=0, err=0; ops_done=1 after handshake.
//  2 Wrap/zero: req1 a=8'h05 b=8'h05 op=001 -> result=8'h00 zero=1 id=1;
//    a=8'hFF b=8'h01 op=000 -> result=8'h00 zero=1.
//  3 Contention: both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1;
//    responses every 2 cycles, ids alternate, no loss/duplication across 8 ops.
//  4 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable, both ready=0,
//    busy=1; resp_ready=1 -> handshake, pending req accepted same cycle.
//  5 Bad op: op=3'b110 a=8'hAA -> result=8'h00 zero=1 err=1; NOT a=8'hAA -> 8'h55 err=0.
//  6 Reset in EXEC and in RESP -> next cycle all outputs at reset values, no response;
//    plus ops_done preloaded near max saturates at 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, opcodes, scheduler states and opcode validity check
package alu_pkg;
  localparam int W = 8;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
  function automatic logic is_valid_op(input logic [2:0] op);
    return op <= OP_NOT;
  endfunction
endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: two request channels plus tagged response channel and status
interface alu_share_ctrl_if #(parameter int W = 8, parameter int CNT_W = 16);
  logic             req0_valid;
  logic             req0_ready;
  logic [W-1:0]     req0_a;
  logic [W-1:0]     req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [W-1:0]     req1_a;
  logic [W-1:0]     req1_b;
  logic [2:0]       req1_op;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [W-1:0]     resp_result;
  logic             resp_zero;
  logic             resp_err;
  logic             busy;
  logic [CNT_W-1:0] ops_done;
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err,
    input  busy, ops_done
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err,
    output busy, ops_done
  );
endinterface

// File: rtl/alu.sv
// alu: 8-bit ADD/SUB/AND/OR/NOT with zero flag, undefined opcodes give 0
module alu
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] result,
  output logic         zero
);
  // combinational datapath, wrapping arithmetic, NOT uses a only
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, ptr names the requester preferred on a tie
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);
  assign gnt = !en ? 2'b00 : &valid ? (ptr ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin scheduler sharing one alu between two requesters
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);
  state_t           state;
  state_t           state_n;
  logic             rr_ptr;
  logic             id_q;
  logic             hs;
  logic             en;
  logic             gid;
  logic [1:0]       gnt;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2:0]       op_q;
  logic [W-1:0]     alu_res;
  logic             alu_zero;
  logic [CNT_W-1:0] cnt;
  assign hs  = state == ST_RESP && bus.resp_ready;
  assign en  = state == ST_IDLE || hs;
  assign gid = gnt[1];
  rr_arb2 u_arb (
    .valid({bus.req1_valid, bus.req0_valid}),
    .ptr  (rr_ptr),
    .en   (en),
    .gnt  (gnt)
  );
  alu u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .result(alu_res),
    .zero  (alu_zero)
  );
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.resp_valid = state == ST_RESP;
  assign bus.busy       = state != ST_IDLE;
  assign bus.ops_done   = cnt;
  // EXEC always advances; RESP holds until taken; otherwise a grant starts a new op
  always_comb begin
    state_n = state == ST_EXEC ? ST_RESP :
              (state == ST_RESP && !bus.resp_ready) ? ST_RESP :
              |gnt ? ST_EXEC : ST_IDLE;
  end
  // operand capture on grant, response capture in EXEC, saturating handshake counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= 1'b0;
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= '0;
      id_q            <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_zero   <= 1'b0;
      bus.resp_err    <= 1'b0;
      cnt             <= '0;
    end else begin
      state <= state_n;
      if (|gnt) begin
        a_q    <= gid ? bus.req1_a : bus.req0_a;
        b_q    <= gid ? bus.req1_b : bus.req0_b;
        op_q   <= gid ? bus.req1_op : bus.req0_op;
        id_q   <= gid;
        rr_ptr <= ~gid;
      end
      if (state == ST_EXEC) begin
        bus.resp_id     <= id_q;
        bus.resp_result <= alu_res;
        bus.resp_zero   <= alu_zero;
        bus.resp_err    <= !is_valid_op(op_q);
      end
      if (hs && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench with a per-cycle reference model and literal checks
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int gseq[$];
  logic [8:0] rseq[$];
  always #5 clk = ~clk;
  alu_share_ctrl_if #(.W(8), .CNT_W(16)) bus ();
  alu_share_ctrl_if #(.W(8), .CNT_W(2)) bus2 ();
  alu_share_ctrl #(.W(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_share_ctrl #(.W(8), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst2), .bus(bus2));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [10:0] ref_op(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] r;
    r = op == 3'd0 ? a + b : op == 3'd1 ? a - b : op == 3'd2 ? a & b :
        op == 3'd3 ? a | b : op == 3'd4 ? ~a : 8'd0;
    return {id, r, r == 8'd0, op > 3'd4};
  endfunction
  int stage = 0;
  logic pref = 1'b0;
  int done = 0;
  logic [10:0] pend = '0;
  logic [10:0] cur = '0;
  always @(negedge clk) begin
    logic can;
    logic [1:0] v;
    logic [1:0] g;
    if (rst) begin
      stage = 0;
      pref = 1'b0;
      done = 0;
    end else begin
      can = stage == 0 || (stage == 2 && bus.resp_ready);
      v = {bus.req1_valid, bus.req0_valid};
      g = !can ? 2'b00 : v == 2'b11 ? (pref ? 2'b10 : 2'b01) : v;
      chk("m_req0_ready", bus.req0_ready, g[0]);
      chk("m_req1_ready", bus.req1_ready, g[1]);
      chk("m_resp_valid", bus.resp_valid, stage == 2);
      chk("m_busy", bus.busy, stage != 0);
      chk("m_ops_done", bus.ops_done, done);
      if (stage == 2)
        chk("m_resp", {bus.resp_id, bus.resp_result, bus.resp_zero, bus.resp_err}, cur);
      if (stage == 2 && bus.resp_ready && done < 65535) done++;
      if (stage == 1) begin
        cur = pend;
        stage = 2;
      end else if (g != 2'b00) begin
        pend = g[1] ? ref_op(1'b1, bus.req1_a, bus.req1_b, bus.req1_op)
                    : ref_op(1'b0, bus.req0_a, bus.req0_b, bus.req0_op);
        pref = ~g[1];
        stage = 1;
      end else if (stage == 2 && bus.resp_ready) begin
        stage = 0;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask
  task automatic drop();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask
  task automatic single(input string nm, input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] er, input logic ez, input logic ee);
    cyc();
    drive(id, a, b, op);
    #1;
    chk({nm, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1);
    cyc();
    drop();
    #1;
    chk({nm, "_exec_valid"}, bus.resp_valid, 0);
    cyc();
    chk({nm, "_valid"}, bus.resp_valid, 1);
    chk({nm, "_resp"}, {bus.resp_id, bus.resp_result, bus.resp_zero, bus.resp_err}, {id, er, ez, ee});
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_out"}, {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_zero, bus.resp_err,
                       bus.busy, bus.req0_ready, bus.req1_ready}, 0);
    chk({nm, "_ops"}, bus.ops_done, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] prev;
    int ndec;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.resp_ready = 1;
    bus2.req0_valid = 0; bus2.req0_a = 0; bus2.req0_b = 0; bus2.req0_op = 0;
    bus2.req1_valid = 0; bus2.req1_a = 0; bus2.req1_b = 0; bus2.req1_op = 0;
    bus2.resp_ready = 1;
    repeat (3) cyc();
    rst = 0;
    #1;
    chk_reset("reset");
    single("t1_add", 1'b0, 8'h0F, 8'h01, 3'b000, 8'h10, 1'b0, 1'b0);
    cyc();
    chk("t1_ops_done", bus.ops_done, 1);
    single("t2_sub", 1'b1, 8'h05, 8'h05, 3'b001, 8'h00, 1'b1, 1'b0);
    single("t2_wrap", 1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b0);
    single("t5_bad", 1'b0, 8'hAA, 8'h00, 3'b110, 8'h00, 1'b1, 1'b1);
    single("t5_not", 1'b1, 8'hAA, 8'h00, 3'b100, 8'h55, 1'b0, 1'b0);
    cyc();
    bus.resp_ready = 0;
    drive(1'b0, 8'h30, 8'h03, 3'b011);
    #1;
    chk("t4_accept", bus.req0_ready, 1);
    cyc();
    bus.req0_valid = 0;
    drive(1'b1, 8'h09, 8'h04, 3'b001);
    #1;
    chk("t4_exec_r1", bus.req1_ready, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_resp", {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_zero, bus.resp_err},
          {1'b1, 1'b0, 8'h33, 1'b0, 1'b0});
      chk("t4_hold_ready", {bus.req0_ready, bus.req1_ready, bus.busy}, 3'b001);
      cyc();
    end
    bus.resp_ready = 1;
    #1;
    chk("t4_release_r1", {bus.req1_ready, bus.resp_valid}, 2'b11);
    cyc();
    drop();
    chk("t4_ops_done", bus.ops_done, 6);
    cyc();
    chk("t4_second", {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_zero, bus.resp_err},
        {1'b1, 1'b1, 8'h05, 1'b0, 1'b0});
    cyc();
    drive(1'b0, 8'h01, 8'h02, 3'b000);
    cyc();
    drop();
    rst = 1;
    cyc();
    rst = 0;
    chk_reset("t6_rst_exec");
    cyc();
    cyc();
    chk("t6_exec_no_resp", bus.resp_valid, 0);
    bus.resp_ready = 0;
    drive(1'b1, 8'h01, 8'h02, 3'b000);
    cyc();
    drop();
    cyc();
    chk("t6_pre_resp", {bus.resp_valid, bus.resp_result}, {1'b1, 8'h03});
    rst = 1;
    cyc();
    rst = 0;
    bus.resp_ready = 1;
    chk_reset("t6_rst_resp");
    cyc();
    cyc();
    chk("t6_resp_no_resp", bus.resp_valid, 0);
    drive(1'b0, 8'h01, 8'h01, 3'b000);
    drive(1'b1, 8'h02, 8'h03, 3'b000);
    for (int i = 0; i < 24; i++) begin
      #1;
      if (bus.req0_ready) gseq.push_back(0);
      if (bus.req1_ready) gseq.push_back(1);
      if (bus.resp_valid && bus.resp_ready) rseq.push_back({bus.resp_id, bus.resp_result});
      cyc();
      if (gseq.size() >= 8) drop();
    end
    chk("t3_grants", gseq.size(), 8);
    chk("t3_resps", rseq.size(), 8);
    for (int k = 0; k < gseq.size(); k++) chk("t3_gnt_order", gseq[k], k % 2);
    for (int k = 0; k < rseq.size(); k++)
      chk("t3_resp", rseq[k], (k % 2) ? {1'b1, 8'h05} : {1'b0, 8'h02});
    rst2 = 0;
    bus2.req0_valid = 1;
    bus2.req0_a = 8'h01;
    bus2.req0_b = 8'h01;
    prev = 2'd0;
    ndec = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (bus2.ops_done < prev) ndec++;
      prev = bus2.ops_done;
    end
    chk("sat_no_wrap", ndec, 0);
    chk("sat_final", bus2.ops_done, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
